// File: rtl/sar_search_pkg.sv
// ---------------------------------------------------------------------------
// sar_search_pkg
//   Shared definitions for the successive-approximation search controller:
//   the controller state encoding and its width.
// ---------------------------------------------------------------------------
package sar_search_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sar_search.sv
// ---------------------------------------------------------------------------
// sar_search
//   Successive-approximation search controller. It drives the B operand of an
//   external combinational magnitude comparator and steps a trial value from
//   MSB to LSB. It uses the gt/eq/lt flags to resolve the unknown A operand.
//
//   Parameter:
//     n       operand width in bits (n >= 2), default 8
//
//   Ports:
//     clk     in   rising-edge clock
//     rst_n   in   asynchronous active-low reset
//     start   in   request a search; honoured only in IDLE
//     cmp_gt  in   comparator flag A > B
//     cmp_eq  in   comparator flag A == B
//     cmp_lt  in   comparator flag A < B
//     cmp_b   out  registered trial value for comparator operand B
//     busy    out  high whenever the controller is not IDLE
//     done    out  one-cycle pulse, result valid from this cycle
//     result  out  resolved value, held until the next accepted start
//     err     out  sticky: some sampled flag set was not one-hot
//
//   Build option:
//     SAR_EARLY_EXIT_EN  when defined, a SEARCH cycle that sees cmp_eq ends
//                        the search at once with result = cmp_b.
// ---------------------------------------------------------------------------
module sar_search #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         cmp_gt,
    input  logic         cmp_eq,
    input  logic         cmp_lt,
    output logic [n-1:0] cmp_b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result,
    output logic         err
);

    import sar_search_pkg::*;

    localparam int               IDX_W    = $clog2(n);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(n - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [n-1:0]     MSB_MASK = {1'b1, {(n-1){1'b0}}};

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [n-1:0]     acc_q, acc_d;
    logic [n-1:0]     cmp_b_q, cmp_b_d;
    logic [n-1:0]     result_q, result_d;
    logic             err_q, err_d;

    logic             keep;
    logic [1:0]       flag_cnt;
    logic [IDX_W-1:0] idx_dec;
    logic [n-1:0]     bit_mask;
    logic [n-1:0]     next_mask;
    logic [n-1:0]     acc_upd;

    // NOTE: every signal written here is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        cmp_b_d  = cmp_b_q;
        result_d = result_q;
        err_d    = err_q;

        // "A >= trial" keeps the bit. Missing flags therefore act as lt.
        keep     = cmp_gt | cmp_eq;
        flag_cnt = {1'b0, cmp_gt} + {1'b0, cmp_eq} + {1'b0, cmp_lt};
        idx_dec  = idx_q - IDX_ONE;

        bit_mask            = '0;
        bit_mask[idx_q]     = 1'b1;
        next_mask           = '0;
        next_mask[idx_dec]  = 1'b1;
        acc_upd             = keep ? (acc_q | bit_mask) : acc_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEARCH;
                    idx_d   = IDX_LAST;
                    acc_d   = '0;
                    cmp_b_d = MSB_MASK;
                    err_d   = 1'b0;
                end
            end

            SEARCH: begin
                acc_d = acc_upd;
                if (flag_cnt != 2'd1) begin
                    err_d = 1'b1;
                end
`ifdef SAR_EARLY_EXIT_EN
                if (cmp_eq) begin
                    // An exact hit already is the answer, so the lower bits need no testing.
                    state_d  = DONE;
                    result_d = cmp_b_q;
                end else
`endif
                if (idx_q == '0) begin
                    state_d  = DONE;
                    result_d = acc_upd;
                end else begin
                    idx_d   = idx_dec;
                    cmp_b_d = acc_upd | next_mask;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            cmp_b_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            cmp_b_q  <= cmp_b_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign cmp_b  = cmp_b_q;
    assign result = result_q;
    assign err    = err_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_sar_search.sv
// ---------------------------------------------------------------------------
// tb_sar_search
//   Self-checking bench for sar_search (n = 8). A behavioural comparator
//   closes the loop on an unknown value a_val. A fault input can force all
//   three flags low. Expected results are queued when a search is launched
//   and compared when done is seen.
// ---------------------------------------------------------------------------
module tb_sar_search;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cmp_gt, cmp_eq, cmp_lt;
    logic [N-1:0] cmp_b;
    logic         busy, done, err;
    logic [N-1:0] result;

    logic [N-1:0] a_val = '0;
    logic         fault = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] exp_q[$];
    logic [N-1:0] seq_q[$];

    always #5 clk = ~clk;

    assign cmp_gt = fault ? 1'b0 : (a_val >  cmp_b);
    assign cmp_eq = fault ? 1'b0 : (a_val == cmp_b);
    assign cmp_lt = fault ? 1'b0 : (a_val <  cmp_b);

    sar_search #(.n(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_eq (cmp_eq),
        .cmp_lt (cmp_lt),
        .cmp_b  (cmp_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one search on A and follow it to done. The latency is counted in
    // cycles after the accepting edge, so a full search reports n+1. The
    // flags are forced low during SEARCH cycle fault_cyc. A start is pulsed
    // during cycle pulse_cyc. A value of 0 disables either action.
    task automatic run_search(input string name, input logic [N-1:0] a,
                              input logic [N-1:0] exp_res, input int exp_lat,
                              input logic exp_err, input int fault_cyc,
                              input int pulse_cyc);
        int lat;
        lat   = 0;
        a_val = a;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(exp_res);
        for (int c = 1; c <= 30; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            if (seq_q.size() > 0) begin
                check($sformatf("%s cmp_b[%0d]", name, c), cmp_b, seq_q.pop_front());
            end
            start = (c == pulse_cyc);
            fault = (c == fault_cyc);
            tick();
        end
        start = 1'b0;
        fault = 1'b0;
        check({name, " latency"}, lat, exp_lat);
        check({name, " result"}, result, exp_q.pop_front());
        check({name, " err"}, err, exp_err);
        tick();
        check({name, " done_pulse"}, done, 1'b0);
        check({name, " busy_fall"}, busy, 1'b0);
    endtask

    initial begin : stimulus
        int dones;
        int last;
        logic seen_done;

        // Reset state.
        tick();
        tick();
        check("rst cmp_b", cmp_b, 8'h00);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst result", result, 8'h00);
        check("rst err", err, 1'b0);
        rst_n = 1'b1;
        tick();

        // Main search with its trial sequence.
        seq_q = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        run_search("a5", 8'hA5, 8'hA5, 9, 1'b0, 0, 0);
        check("a5 seq_consumed", seq_q.size(), 0);

        // Boundaries.
        run_search("zero", 8'h00, 8'h00, 9, 1'b0, 0, 0);
        run_search("ones", 8'hFF, 8'hFF, 9, 1'b0, 0, 0);

        // All flags low in the 3rd SEARCH cycle: bit 5 is dropped and err sticks.
        run_search("fault", 8'hFF, 8'hDF, 9, 1'b1, 3, 0);
        run_search("err_clear", 8'h12, 8'h12, 9, 1'b0, 0, 0);

        // A start pulse mid-search is ignored.
        run_search("mid_start", 8'h3C, 8'h3C, 9, 1'b0, 0, 3);
        tick();
        check("mid_start no_relaunch", busy, 1'b0);

`ifdef SAR_EARLY_EXIT_EN
        run_search("ee_80", 8'h80, 8'h80, 2, 1'b0, 0, 0);
        run_search("ee_01", 8'h01, 8'h01, 9, 1'b0, 0, 0);
`endif

        // Reset at cycle 4 of a search.
        a_val = 8'h77;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst cmp_b", cmp_b, 8'h00);
        check("midrst busy", busy, 1'b0);
        check("midrst done", done, 1'b0);
        check("midrst result", result, 8'h00);
        check("midrst err", err, 1'b0);
        tick();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            seen_done = seen_done | done;
        end
        check("midrst no_done", seen_done, 1'b0);
        check("midrst idle", busy, 1'b0);

        run_search("post_rst", 8'h6E, 8'h6E, 9, 1'b0, 0, 0);

        // Back-to-back: start held high relaunches every n+2 cycles.
        a_val = 8'h5A;
        for (int k = 0; k < 3; k++) exp_q.push_back(8'h5A);
        start = 1'b1;
        dones = 0;
        last  = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (done) begin
                check($sformatf("b2b result[%0d]", dones), result, exp_q.pop_front());
                if (dones > 0) begin
                    check($sformatf("b2b period[%0d]", dones), c - last, 10);
                end
                last = c;
                dones++;
                if (dones == 3) break;
            end
        end
        start = 1'b0;
        check("b2b done_count", dones, 3);
        for (int c = 0; c < 15 && busy; c++) tick();
        check("b2b idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
